// File: rtl/pll_lock_detect_if.sv
// Bundle of the lock detector's functional signals (everything except clock/reset).
// With PLL_LOCK_LOL_EN defined the sticky loss-of-lock pair lol_flag/lol_clr
// is added; otherwise those signals do not exist.
interface pll_lock_detect_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             osc;
  logic [4:0]       div;
  logic             locked;
  logic [CNT_W-1:0] meas;
  logic             meas_valid;
`ifdef PLL_LOCK_LOL_EN
  logic             lol_flag;
  logic             lol_clr;

  modport master (output enable, osc, div, lol_clr,
                  input  locked, meas, meas_valid, lol_flag);
  modport slave  (input  enable, osc, div, lol_clr,
                  output locked, meas, meas_valid, lol_flag);
`else
  modport master (output enable, osc, div,
                  input  locked, meas, meas_valid);
  modport slave  (input  enable, osc, div,
                  output locked, meas, meas_valid);
`endif
endinterface

// File: rtl/pll_lock_detect.sv
// PLL lock detector, clocked by the PLL output clock.
// Measures PLL cycles per reference (osc) period, compares against div with a
// +/-TOL window, and runs an IDLE/ACQUIRE/LOCKED FSM with hysteresis.
// Optional feature macro: PLL_LOCK_LOL_EN (sticky loss-of-lock flag).
module pll_lock_detect #(
  parameter int CNT_W      = 8,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 2
) (
  input  logic               clock,
  input  logic               reset,
  pll_lock_detect_if.slave   bus
);

  localparam int EW = CNT_W + 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [GW-1:0]    LOCK_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0]    UNLOCK_LAST = BW'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             osc_s1_q, osc_s2_q, osc_e_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             armed_q, armed_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;

  logic             tick;
  logic             timeout;
  logic             match;
  logic [CNT_W-1:0] meas_new;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Widened unsigned compare so |meas - div| never wraps.
  function automatic logic in_tol(input logic [CNT_W-1:0] m, input logic [4:0] d);
    logic [EW-1:0] a, b, diff;
    a    = EW'(m);
    b    = EW'(d);
    diff = (a >= b) ? (a - b) : (b - a);
    return (d != 5'd0) && (diff <= EW'(TOL));
  endfunction

  assign tick     = osc_s2_q & ~osc_e_q;
  assign timeout  = (per_cnt_q == CNT_MAX) && !tick;
  assign meas_new = sat_inc(per_cnt_q);
  assign match    = in_tol(meas_new, bus.div);

  // osc synchroniser + edge register; free-running so edges are seen right after enable
  always_ff @(posedge clock) begin
    if (reset) begin
      osc_s1_q <= 1'b0;
      osc_s2_q <= 1'b0;
      osc_e_q  <= 1'b0;
    end else begin
      osc_s1_q <= bus.osc;
      osc_s2_q <= osc_s1_q;
      osc_e_q  <= osc_s2_q;
    end
  end

  // Next-state: period counter, measurement capture and lock FSM
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = sat_inc(per_cnt_q);
    meas_d       = meas_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    armed_d      = armed_q;
    good_d       = good_q;
    bad_d        = bad_q;
    if (!bus.enable) begin
      state_d   = IDLE;
      per_cnt_d = '0;
      locked_d  = 1'b0;
      armed_d   = 1'b0;
      good_d    = '0;
      bad_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          armed_d = 1'b0;
          good_d  = '0;
          bad_d   = '0;
        end
        ACQUIRE, LOCKED: begin
          if (tick) begin
            per_cnt_d = '0;
            armed_d   = 1'b1;
            // first tick after (re)start only arms the measurement
            if (armed_q) begin
              meas_d       = meas_new;
              meas_valid_d = 1'b1;
              if (state_q == ACQUIRE) begin
                if (!match) begin
                  good_d = '0;
                end else if (good_q == LOCK_LAST) begin
                  good_d   = good_q + GW'(1);
                  bad_d    = '0;
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end else begin
                  good_d = good_q + GW'(1);
                end
              end else begin
                if (match) begin
                  bad_d = '0;
                end else if (bad_q == UNLOCK_LAST) begin
                  bad_d    = '0;
                  good_d   = '0;
                  state_d  = ACQUIRE;
                  locked_d = 1'b0;
                end else begin
                  bad_d = bad_q + BW'(1);
                end
              end
            end
          end else if (timeout) begin
            // osc missing: treat as a miss and restart measurement
            per_cnt_d = '0;
            armed_d   = 1'b0;
            good_d    = '0;
            bad_d     = '0;
            state_d   = ACQUIRE;
            locked_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      armed_q      <= 1'b0;
      good_q       <= '0;
      bad_q        <= '0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      armed_q      <= armed_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.meas       = meas_q;
  assign bus.meas_valid = meas_valid_q;

`ifdef PLL_LOCK_LOL_EN
  logic lol_set;
  logic lol_q, lol_d;

  assign lol_set = (state_q == LOCKED) && (state_d == ACQUIRE);

  // Sticky loss-of-lock; a set on the same cycle as a clear takes priority
  always_comb begin
    lol_d = lol_q;
    if (lol_set)          lol_d = 1'b1;
    else if (bus.lol_clr) lol_d = 1'b0;
  end

  // Loss-of-lock register
  always_ff @(posedge clock) begin
    if (reset) lol_q <= 1'b0;
    else       lol_q <= lol_d;
  end

  assign bus.lol_flag = lol_q;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect (default parameters, div=8, TOL=1).
module tb_pll_lock_detect;

  logic clk;
  logic rst;

  pll_lock_detect_if #(.CNT_W(8)) bus ();

  pll_lock_detect #(
    .CNT_W(8), .TOL(1), .LOCK_CNT(16), .UNLOCK_CNT(2)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nvalid, bad_meas, lock_at, unlock_at;
  int exp_meas, prev_per;
  logic prev_locked;
  logic lol_at_unlock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock; observe outputs 1 time unit after the edge.
  task automatic clk1();
    @(posedge clk);
    #1;
    if (bus.meas_valid === 1'b1) begin
      nvalid++;
      if (bus.meas !== 8'(exp_meas)) bad_meas++;
    end
    if (bus.locked === 1'b1 && prev_locked === 1'b0) lock_at = nvalid;
    if (bus.locked === 1'b0 && prev_locked === 1'b1) begin
      unlock_at = nvalid;
`ifdef PLL_LOCK_LOL_EN
      lol_at_unlock = bus.lol_flag;
`endif
    end
    prev_locked = bus.locked;
  endtask

  task automatic clkn(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  // One osc period of 'per' clocks, rising edge first. Any measurement
  // completed here covers the previous period.
  task automatic osc_period(input int per);
    exp_meas = prev_per;
    bus.osc = 1'b1;
    clkn(per / 2);
    bus.osc = 1'b0;
    clkn(per - per / 2);
    prev_per = per;
  endtask

  task automatic clr_stats();
    nvalid    = 0;
    bad_meas  = 0;
    lock_at   = -1;
    unlock_at = -1;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.osc    = 1'b0;
    bus.div    = 5'd8;
`ifdef PLL_LOCK_LOL_EN
    bus.lol_clr = 1'b0;
`endif
    prev_locked   = 1'b0;
    lol_at_unlock = 1'b0;
    prev_per      = 0;
    exp_meas      = 0;
    clr_stats();
    clkn(3);
    chk("reset_locked", 32'(bus.locked), 0);
    chk("reset_meas", 32'(bus.meas), 0);
    chk("reset_meas_valid", 32'(bus.meas_valid), 0);
`ifdef PLL_LOCK_LOL_EN
    chk("reset_lol", 32'(bus.lol_flag), 0);
`endif

    // Test 1: 20 periods of 8 -> 19 measurements, lock on the 16th
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 20; i++) osc_period(8);
    chk("t1_nvalid", 32'(nvalid), 19);
    chk("t1_bad_meas", 32'(bad_meas), 0);
    chk("t1_lock_at", 32'(lock_at), 16);
    chk("t1_locked", 32'(bus.locked), 1);
    chk("t1_meas", 32'(bus.meas), 8);

    // Test 2: period 12 -> unlock on the second miss
    clr_stats();
    osc_period(12);
    osc_period(12);
    chk("t2_locked_after_1miss", 32'(bus.locked), 1);
    osc_period(12);
    chk("t2_locked", 32'(bus.locked), 0);
    chk("t2_unlock_at", 32'(unlock_at), 3);
    chk("t2_state_acq", 32'(dut.state_q), 1);
    chk("t2_meas", 32'(bus.meas), 12);
    chk("t2_bad_meas", 32'(bad_meas), 0);
`ifdef PLL_LOCK_LOL_EN
    chk("t6_lol_after_unlock", 32'(bus.lol_flag), 1);
`endif

    // Test 3a: alternating 7/9 all match
    clr_stats();
    osc_period(7);
    for (int i = 0; i < 16; i++) osc_period((i % 2 == 0) ? 9 : 7);
    chk("t3_lock_at", 32'(lock_at), 17);
    chk("t3_locked", 32'(bus.locked), 1);
    chk("t3_bad_meas", 32'(bad_meas), 0);
`ifdef PLL_LOCK_LOL_EN
    chk("t6_lol_after_relock", 32'(bus.lol_flag), 1);
    bus.lol_clr = 1'b1;
    clk1();
    bus.lol_clr = 1'b0;
    chk("t6_lol_cleared", 32'(bus.lol_flag), 0);
    bus.lol_clr = 1'b1;
`endif

    // Test 3b: period 10 (|10-8|=2 > TOL) never locks
    clr_stats();
    for (int i = 0; i < 20; i++) osc_period(10);
    chk("t3b_unlock_at", 32'(unlock_at), 3);
    chk("t3b_never_lock", 32'(lock_at), -1);
    chk("t3b_locked", 32'(bus.locked), 0);
    chk("t3b_meas", 32'(bus.meas), 10);
    chk("t3b_good", 32'(dut.good_q), 0);
    chk("t3b_bad_meas", 32'(bad_meas), 0);
`ifdef PLL_LOCK_LOL_EN
    chk("t6_set_wins_over_clr", 32'(lol_at_unlock), 1);
    chk("t6_clr_after_set", 32'(bus.lol_flag), 0);
    bus.lol_clr = 1'b0;
`endif

    // Test 4: relock at 8, then osc stuck low -> timeout
    clr_stats();
    for (int i = 0; i < 17; i++) osc_period(8);
    chk("t4_lock_at", 32'(lock_at), 17);
    chk("t4_locked", 32'(bus.locked), 1);
    clkn(250);
    chk("t4_locked_before_timeout", 32'(bus.locked), 1);
    clk1();
    chk("t4_locked_after_timeout", 32'(bus.locked), 0);
    chk("t4_state_acq", 32'(dut.state_q), 1);
    chk("t4_disarmed", 32'(dut.armed_q), 0);
    chk("t4_no_meas", 32'(nvalid), 17);
`ifdef PLL_LOCK_LOL_EN
    chk("t6_lol_on_timeout", 32'(bus.lol_flag), 1);
`endif
    osc_period(8);
    chk("t4_arm_only", 32'(nvalid), 17);
    osc_period(8);
    chk("t4_meas_after_arm", 32'(nvalid), 18);
    chk("t4_meas_val", 32'(bus.meas), 8);
    chk("t4_bad_meas", 32'(bad_meas), 0);

    // Test 5: disable at good=10, re-enable restarts acquisition
    for (int i = 0; i < 9; i++) osc_period(8);
    chk("t5_good10", 32'(dut.good_q), 10);
    bus.enable = 1'b0;
    clkn(3);
    chk("t5_state_idle", 32'(dut.state_q), 0);
    chk("t5_good_cleared", 32'(dut.good_q), 0);
    chk("t5_locked", 32'(bus.locked), 0);
    chk("t5_meas_hold", 32'(bus.meas), 8);
    chk("t5_meas_valid", 32'(bus.meas_valid), 0);
    clr_stats();
    bus.enable = 1'b1;
    for (int i = 0; i < 16; i++) osc_period(8);
    chk("t5_not_yet_locked", 32'(bus.locked), 0);
    chk("t5_nvalid", 32'(nvalid), 15);
    osc_period(8);
    chk("t5_lock_at", 32'(lock_at), 16);
    chk("t5_locked_final", 32'(bus.locked), 1);
    chk("t5_bad_meas", 32'(bad_meas), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
